// File: rtl/credit_bcd_tracker_if.sv
// Bundle of the credit tracker's event inputs and display/status outputs.
// The master side (machine controller) issues events. The slave side (the tracker) answers them.
interface credit_bcd_tracker_if;
    logic        coin_n;
    logic        coin_d;
    logic        coin_q;
    logic        coin_dl;
    logic        vend_req;
    logic        refund_req;
    logic [3:0]  dig1;
    logic [3:0]  dig2;
    logic [3:0]  dig3;
    logic [3:0]  dig4;
    logic        vend_ok;
    logic        vend_fail;
    logic        coin_reject;
    logic [13:0] change_amt;
    logic        busy;

    modport master (
        output coin_n, coin_d, coin_q, coin_dl, vend_req, refund_req,
        input  dig1, dig2, dig3, dig4, vend_ok, vend_fail, coin_reject, change_amt, busy
    );

    modport slave (
        input  coin_n, coin_d, coin_q, coin_dl, vend_req, refund_req,
        output dig1, dig2, dig3, dig4, vend_ok, vend_fail, coin_reject, change_amt, busy
    );
endinterface

// File: rtl/credit_bcd_tracker.sv
// Vending credit accumulator with a sequential double-dabble converter that
// feeds a four-digit BCD display (dig1 = thousands ... dig4 = ones).
// Credit updates set a dirty flag. The converter picks it up when idle and
// publishes all four digits atomically, so the display always shows a value
// that credit actually held and then converges to the latest total.
module credit_bcd_tracker #(
    parameter int unsigned PRICE      = 125,
    parameter int unsigned MAX_CREDIT = 995
) (
    input  logic                 clk,
    input  logic                 clr,
    credit_bcd_tracker_if.slave  bus
);

    localparam logic [13:0] PRICE_C = 14'(PRICE);
    localparam logic [14:0] MAX_C   = 15'(MAX_CREDIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    function automatic logic [29:0] dabble_step(input logic [29:0] s);
        logic [29:0] adj;
        adj = s;
        for (int i = 0; i < 4; i++) begin
            if (adj[14 + 4*i +: 4] >= 4'd5) begin
                adj[14 + 4*i +: 4] = adj[14 + 4*i +: 4] + 4'd3;
            end else begin
                adj[14 + 4*i +: 4] = adj[14 + 4*i +: 4];
            end
        end
        return {adj[28:0], 1'b0};
    endfunction

    logic [13:0] credit_q,      credit_d;
    logic [13:0] change_amt_q,  change_amt_d;
    logic        vend_ok_q,     vend_ok_d;
    logic        vend_fail_q,   vend_fail_d;
    logic        coin_reject_q, coin_reject_d;
    logic        pending_q,     pending_d;
    logic        busy_q,        busy_d;
    logic        restart_q,     restart_d;
    logic [29:0] shift_q,       shift_d;
    logic [3:0]  cnt_q,         cnt_d;
    logic [15:0] dig_q,         dig_d;
    state_t      state_q,       state_d;

    logic [13:0] coin_val_s;
    logic [2:0]  coin_cnt_s;
    logic        any_coin_s;
    logic        multi_coin_s;
    logic [14:0] coin_sum_s;
    logic        load_s;

    // Pick the highest-value coin and flag when more than one coin arrives.
    always_comb begin
        coin_cnt_s = {2'b00, bus.coin_n} + {2'b00, bus.coin_d}
                   + {2'b00, bus.coin_q} + {2'b00, bus.coin_dl};
        any_coin_s   = (coin_cnt_s != 3'd0);
        multi_coin_s = (coin_cnt_s > 3'd1);
        if (bus.coin_dl) begin
            coin_val_s = 14'd100;
        end else if (bus.coin_q) begin
            coin_val_s = 14'd25;
        end else if (bus.coin_d) begin
            coin_val_s = 14'd10;
        end else if (bus.coin_n) begin
            coin_val_s = 14'd5;
        end else begin
            coin_val_s = 14'd0;
        end
        coin_sum_s = {1'b0, credit_q} + {1'b0, coin_val_s};
    end

    // Resolve one event per cycle: refund > vend > coin.
    always_comb begin
        credit_d      = credit_q;
        change_amt_d  = change_amt_q;
        vend_ok_d     = 1'b0;
        vend_fail_d   = 1'b0;
        coin_reject_d = 1'b0;
        if (bus.refund_req) begin
            change_amt_d  = credit_q;
            credit_d      = 14'd0;
            coin_reject_d = any_coin_s;
        end else if (bus.vend_req) begin
            coin_reject_d = any_coin_s;
            if (credit_q >= PRICE_C) begin
                credit_d  = credit_q - PRICE_C;
                vend_ok_d = 1'b1;
            end else begin
                vend_fail_d = 1'b1;
            end
        end else if (any_coin_s) begin
            if (coin_sum_s <= MAX_C) begin
                credit_d      = coin_sum_s[13:0];
                coin_reject_d = multi_coin_s;
            end else begin
                coin_reject_d = 1'b1;
            end
        end else begin
            credit_d = credit_q;
        end
    end

    // Converter FSM: snapshot credit, run 14 dabble steps, publish digits.
    // When credit moved during a conversion, DONE keeps busy high and the
    // FSM spends one settling cycle in IDLE before reloading.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        restart_d = restart_q;
        dig_d     = dig_q;
        load_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (restart_q) begin
                    restart_d = 1'b0;
                end else if (pending_q) begin
                    load_s  = 1'b1;
                    shift_d = {16'd0, credit_q};
                    busy_d  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = ST_SHIFT;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                shift_d = dabble_step(shift_q);
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                dig_d     = shift_q[29:14];
                busy_d    = pending_q;
                restart_d = pending_q;
                state_d   = ST_IDLE;
            end
            default: begin
                busy_d    = 1'b0;
                restart_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
        pending_d = (credit_d != credit_q) | (pending_q & ~load_s);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            credit_q      <= 14'd0;
            change_amt_q  <= 14'd0;
            vend_ok_q     <= 1'b0;
            vend_fail_q   <= 1'b0;
            coin_reject_q <= 1'b0;
            pending_q     <= 1'b0;
            busy_q        <= 1'b0;
            restart_q     <= 1'b0;
            shift_q       <= 30'd0;
            cnt_q         <= 4'd0;
            dig_q         <= 16'd0;
            state_q       <= ST_IDLE;
        end else begin
            credit_q      <= credit_d;
            change_amt_q  <= change_amt_d;
            vend_ok_q     <= vend_ok_d;
            vend_fail_q   <= vend_fail_d;
            coin_reject_q <= coin_reject_d;
            pending_q     <= pending_d;
            busy_q        <= busy_d;
            restart_q     <= restart_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            dig_q         <= dig_d;
            state_q       <= state_d;
        end
    end

    assign bus.dig1        = dig_q[15:12];
    assign bus.dig2        = dig_q[11:8];
    assign bus.dig3        = dig_q[7:4];
    assign bus.dig4        = dig_q[3:0];
    assign bus.vend_ok     = vend_ok_q;
    assign bus.vend_fail   = vend_fail_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.change_amt  = change_amt_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_credit_bcd_tracker.sv
// Scoreboard bench for credit_bcd_tracker: stimulus pushes expected pulses
// and expected display updates (value plus arrival cycle); a negedge monitor
// pops and compares whenever the DUT shows a pulse or a display update.
module tb_credit_bcd_tracker;

    localparam logic [5:0] EV_REF  = 6'b100000;
    localparam logic [5:0] EV_VEND = 6'b010000;
    localparam logic [5:0] EV_DL   = 6'b001000;
    localparam logic [5:0] EV_Q    = 6'b000100;
    localparam logic [5:0] EV_D    = 6'b000010;
    localparam logic [5:0] EV_N    = 6'b000001;

    typedef struct {
        logic [15:0] digs;
        int          at;
    } disp_t;

    logic clk;
    logic clr;
    int   cyc;
    int   n_chk;
    int   n_fail;

    disp_t       disp_exp[$];
    logic [2:0]  pulse_exp[$];
    logic [15:0] prev_digs;
    logic        prev_busy;

    credit_bcd_tracker_if bus ();

    credit_bcd_tracker #(.PRICE(125), .MAX_CREDIT(995)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to time display arrivals.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: compare every pulse and every display update against the queues.
    always @(negedge clk) begin
        logic [2:0]  pls;
        logic [15:0] digs;
        disp_t       e;
        if (clr) begin
            prev_digs <= 16'd0;
            prev_busy <= 1'b0;
        end else begin
            pls  = {bus.vend_ok, bus.vend_fail, bus.coin_reject};
            digs = {bus.dig1, bus.dig2, bus.dig3, bus.dig4};
            if (pls != 3'b000) begin
                if (pulse_exp.size() == 0) begin
                    check("unexpected_pulse", {29'd0, pls}, 32'd0);
                end else begin
                    check("pulse", {29'd0, pls}, {29'd0, pulse_exp.pop_front()});
                end
            end
            if ((prev_busy && !bus.busy) || (digs != prev_digs)) begin
                if (disp_exp.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_display: got %h with nothing expected at cycle %0d",
                             digs, cyc);
                end else begin
                    e = disp_exp.pop_front();
                    check("display_digits", {16'd0, digs}, {16'd0, e.digs});
                    check("display_cycle", cyc, e.at);
                end
            end
            prev_digs <= digs;
            prev_busy <= bus.busy;
        end
    end

    // Apply one event for exactly one sampling edge; returns that edge's cycle.
    task automatic ev(input logic [5:0] b, output int e0);
        @(posedge clk);
        #1;
        {bus.refund_req, bus.vend_req, bus.coin_dl, bus.coin_q, bus.coin_d, bus.coin_n} = b;
        @(posedge clk);
        #1;
        e0 = cyc;
        {bus.refund_req, bus.vend_req, bus.coin_dl, bus.coin_q, bus.coin_d, bus.coin_n} = 6'b000000;
    endtask

    // Event plus its expected pulse and, optionally, display 16 edges later.
    task automatic step(input logic [5:0] b, input logic has_disp, input logic [15:0] digs,
                        input logic [2:0] pls, input int gap);
        int    e0;
        disp_t d;
        ev(b, e0);
        if (pls != 3'b000) pulse_exp.push_back(pls);
        if (has_disp) begin
            d.digs = digs;
            d.at   = e0 + 16;
            disp_exp.push_back(d);
        end
        repeat (gap) @(posedge clk);
    endtask

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int    e0;
        int    e5;
        int    lows;
        int    highs;
        disp_t d;
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        clr    = 1'b1;
        {bus.refund_req, bus.vend_req, bus.coin_dl, bus.coin_q, bus.coin_d, bus.coin_n} = 6'b000000;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        check("reset_digits", {16'd0, bus.dig1, bus.dig2, bus.dig3, bus.dig4}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_change", {18'd0, bus.change_amt}, 32'd0);
        check("reset_pulses", {29'd0, bus.vend_ok, bus.vend_fail, bus.coin_reject}, 32'd0);

        // Five quarters.
        step(EV_Q, 1'b1, 16'h0025, 3'b000, 20);
        step(EV_Q, 1'b1, 16'h0050, 3'b000, 20);
        step(EV_Q, 1'b1, 16'h0075, 3'b000, 20);
        step(EV_Q, 1'b1, 16'h0100, 3'b000, 20);
        step(EV_Q, 1'b1, 16'h0125, 3'b000, 20);

        // Vend at exactly the price, then vend with no credit.
        step(EV_VEND, 1'b1, 16'h0000, 3'b100, 20);
        step(EV_VEND, 1'b0, 16'h0000, 3'b010, 0);
        highs = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.busy) highs++;
        end
        check("busy_after_vend_fail", highs, 32'd0);

        // Fill to the 995 cap, then a nickel that must bounce.
        for (int i = 1; i <= 9; i++) begin
            step(EV_DL, 1'b1, {4'd0, 4'(i), 8'h00}, 3'b000, 20);
        end
        step(EV_Q, 1'b1, 16'h0925, 3'b000, 20);
        step(EV_Q, 1'b1, 16'h0950, 3'b000, 20);
        step(EV_Q, 1'b1, 16'h0975, 3'b000, 20);
        step(EV_D, 1'b1, 16'h0985, 3'b000, 20);
        step(EV_D, 1'b1, 16'h0995, 3'b000, 20);
        step(EV_N, 1'b0, 16'h0000, 3'b001, 20);

        // Refund everything.
        step(EV_REF, 1'b1, 16'h0000, 3'b000, 20);
        check("change_995", {18'd0, bus.change_amt}, 32'd995);

        // Dollar and nickel together: dollar counts, nickel rejected.
        step(EV_DL | EV_N, 1'b1, 16'h0100, 3'b001, 20);
        step(EV_REF, 1'b1, 16'h0000, 3'b000, 20);
        check("change_100", {18'd0, bus.change_amt}, 32'd100);

        // Dime, then quarter mid-conversion: 0010 at E16, 0035 at E33.
        ev(EV_D, e0);
        d.digs = 16'h0010;
        d.at   = e0 + 16;
        disp_exp.push_back(d);
        d.digs = 16'h0035;
        d.at   = e0 + 33;
        disp_exp.push_back(d);
        repeat (3) @(posedge clk);
        ev(EV_Q, e5);
        lows = 0;
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            if (!bus.busy) lows++;
        end
        check("busy_continuous", lows, 32'd0);
        repeat (20) @(posedge clk);

        // Refund and vend together at 35: refund wins, no vend pulse.
        step(EV_REF | EV_VEND, 1'b1, 16'h0000, 3'b000, 20);
        check("change_35", {18'd0, bus.change_amt}, 32'd35);

        // Reset in the middle of a conversion.
        ev(EV_N, e0);
        repeat (5) @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        check("clr_digits", {16'd0, bus.dig1, bus.dig2, bus.dig3, bus.dig4}, 32'd0);
        check("clr_busy", {31'd0, bus.busy}, 32'd0);
        check("clr_change", {18'd0, bus.change_amt}, 32'd0);
        check("clr_pulses", {29'd0, bus.vend_ok, bus.vend_fail, bus.coin_reject}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;

        // Normal operation after reset.
        step(EV_DL, 1'b1, 16'h0100, 3'b000, 20);

        check("pulse_queue_drained", pulse_exp.size(), 32'd0);
        check("display_queue_drained", disp_exp.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
